// File: rtl/mem_ctrl.sv
// Purpose : byte-serial controller sharing one 8-bit RAM port between instruction fetch and the MEM stage.
// Latency : reads finish N+1 edges after acceptance and writes N edges after, for N = 1/2/4 bytes. Done pulses one cycle.
// Backpres: requesters hold req until their done. busy is high for the whole transaction and feeds the stall controller.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (always one word)
//   if_done/if_inst             fetch done pulse and fetched word (held until next if_done)
//   mem_req/we/len/addr/wdata   data request; len 0/1/2-3 = 1/2/4 bytes, little-endian
//   mem_done/mem_rdata          data done pulse and zero-extended read data
//   flush                       cancels a pending or in-flight fetch
//   busy                        high while not idle
//   ram_a/ram_dout/ram_wr       registered RAM address, write byte, write enable
//   ram_din                     RAM read byte, valid the cycle after its address
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_wr,
   input  logic [7:0]  ram_din
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_e;

   state_e      state_q,     state_d;
   logic [2:0]  cnt_q,       cnt_d;
   logic [2:0]  nbytes_q,    nbytes_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [31:0] rbuf_q,      rbuf_d;
   logic [31:0] ram_a_q,     ram_a_d;
   logic [7:0]  ram_dout_q,  ram_dout_d;
   logic        ram_wr_q,    ram_wr_d;
   logic        if_done_q,   if_done_d;
   logic [31:0] if_inst_q,   if_inst_d;
   logic        mem_done_q,  mem_done_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   // Read word with the byte arriving this cycle merged in.
   logic [31:0] rd_word;

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'd0:    len_to_n = 3'd1;
         2'd1:    len_to_n = 3'd2;
         default: len_to_n = 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         default: byte_sel = w[31:24];
      endcase
   endfunction

   // In a read state cnt_q counts edges since acceptance; the byte for
   // address base+k lands on ram_din when cnt_q == k+1.
   always_comb begin
      rd_word = rbuf_q;
      case (cnt_q)
         3'd1:    rd_word[7:0]   = ram_din;
         3'd2:    rd_word[15:8]  = ram_din;
         3'd3:    rd_word[23:16] = ram_din;
         3'd4:    rd_word[31:24] = ram_din;
         default: rd_word        = rbuf_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;
      if_done_d   = 1'b0;
      if_inst_d   = if_inst_q;
      mem_done_d  = 1'b0;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         IDLE: begin
            // The done cycle is skipped so a requester can drop or
            // replace its request before being considered again.
            if (!if_done_q && !mem_done_q) begin
               if (mem_req) begin
                  nbytes_d = len_to_n(mem_len);
                  wdata_d  = mem_wdata;
                  ram_a_d  = mem_addr;
                  rbuf_d   = 32'd0;
                  if (mem_we) begin
                     // First byte goes out straight away in the next cycle.
                     state_d    = MEM_WR;
                     ram_dout_d = mem_wdata[7:0];
                     ram_wr_d   = 1'b1;
                     cnt_d      = 3'd1;
                  end else begin
                     state_d = MEM_RD;
                     cnt_d   = 3'd0;
                  end
               end else if (if_req && !flush) begin
                  state_d  = IF_RD;
                  nbytes_d = 3'd4;
                  ram_a_d  = if_addr;
                  rbuf_d   = 32'd0;
                  cnt_d    = 3'd0;
               end
            end
         end

         IF_RD, MEM_RD: begin
            if (state_q == IF_RD && flush) begin
               // Abandon the fetch; bytes still in flight are ignored.
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               if (cnt_q + 3'd1 < nbytes_q) begin
                  ram_a_d = ram_a_q + 32'd1;
               end
               rbuf_d = rd_word;
               if (cnt_q == nbytes_q) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
                  if (state_q == IF_RD) begin
                     if_done_d = 1'b1;
                     if_inst_d = rd_word;
                  end else begin
                     mem_done_d  = 1'b1;
                     mem_rdata_d = rd_word;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         MEM_WR: begin
            // cnt_q = bytes already presented on the RAM port.
            if (cnt_q == nbytes_q) begin
               state_d    = IDLE;
               cnt_d      = 3'd0;
               mem_done_d = 1'b1;
            end else begin
               ram_a_d    = ram_a_q + 32'd1;
               ram_dout_d = byte_sel(wdata_q, cnt_q[1:0]);
               ram_wr_d   = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         nbytes_q    <= 3'd0;
         wdata_q     <= 32'd0;
         rbuf_q      <= 32'd0;
         ram_a_q     <= 32'd0;
         ram_dout_q  <= 8'd0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         if_inst_q   <= 32'd0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         wdata_q     <= wdata_d;
         rbuf_q      <= rbuf_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_done_q   <= if_done_d;
         if_inst_q   <= if_inst_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign ram_a     = ram_a_q;
   assign ram_dout  = ram_dout_q;
   assign ram_wr    = ram_wr_q;
   assign if_done   = if_done_q;
   assign if_inst   = if_inst_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model, reference memory, directed scenarios then random transactions.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        flush;
   logic        busy;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din;

   int errors = 0;
   int checks = 0;

   logic [7:0]  ram     [logic [31:0]];  // RAM model contents
   logic [7:0]  ref_mem [logic [31:0]];  // expected memory contents
   logic [39:0] wlog[$];                 // {addr, byte} of every RAM write
   logic [31:0] last_inst;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .flush(flush), .busy(busy),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   // Synchronous RAM: data for the address seen this cycle appears next cycle.
   always @(posedge clk) begin
      ram_din <= ram.exists(ram_a) ? ram[ram_a] : init_byte(ram_a);
      if (ram_wr === 1'b1) begin
         ram[ram_a] = ram_dout;
         wlog.push_back({ram_a, ram_dout});
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_ram_wr"},    ram_wr,    0);
      check({tag, "_ram_a"},     ram_a,     0);
      check({tag, "_ram_dout"},  ram_dout,  0);
      check({tag, "_if_done"},   if_done,   0);
      check({tag, "_mem_done"},  mem_done,  0);
      check({tag, "_if_inst"},   if_inst,   0);
      check({tag, "_mem_rdata"}, mem_rdata, 0);
   endtask

   // Issues one transaction from idle, waits (bounded) for its done and
   // checks latency, address sequence, busy, data and RAM write activity.
   task automatic do_req(input string tag, input bit is_mem, input bit we,
                         input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata);
      int n, e, exp_lat;
      bit seen, addr_ok, busy_ok, done_now;
      logic [31:0] exp_data, obs;
      n = (!is_mem) ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      exp_lat = (is_mem && we) ? n : n + 1;
      exp_data = 32'd0;
      if (!(is_mem && we))
         for (int k = 0; k < n; k++) exp_data[8*k +: 8] = ref_rd(addr + 32'(k));
      wlog.delete();
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      e = -1; seen = 0; addr_ok = 1; busy_ok = 1;
      while (!seen && e < 20) begin
         @(posedge clk); e++;
         @(negedge clk);
         if (e < n && ram_a !== addr + 32'(e)) addr_ok = 0;
         done_now = is_mem ? mem_done : if_done;
         if (done_now === 1'b1) seen = 1;
         else if (busy !== 1'b1) busy_ok = 0;
      end
      mem_req = 1'b0; if_req = 1'b0;
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_latency"}, e, exp_lat);
      check({tag, "_addr_seq"}, addr_ok, 1);
      check({tag, "_busy_during"}, busy_ok, 1);
      check({tag, "_busy_done_cycle"}, busy, 0);
      if (!(is_mem && we)) begin
         obs = is_mem ? mem_rdata : if_inst;
         check({tag, "_rdata"}, obs, exp_data);
         if (!is_mem) last_inst = exp_data;
      end
      @(negedge clk);
      done_now = is_mem ? mem_done : if_done;
      check({tag, "_single_pulse"}, done_now, 0);
      if (is_mem && we) begin
         check({tag, "_wr_count"}, wlog.size(), n);
         for (int k = 0; k < n && k < wlog.size(); k++) begin
            check({tag, "_wr_byte"}, wlog[k], {addr + 32'(k), wdata[8*k +: 8]});
            ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
         end
      end else begin
         check({tag, "_no_writes"}, wlog.size(), 0);
         if (!is_mem) check({tag, "_inst_held"}, if_inst, exp_data);
      end
   endtask

   initial begin
      int e;
      bit seen, quiet;
      logic [1:0]  rl;
      logic [31:0] ra;

      rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
      mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0; flush = 1'b0; ram_din = 8'd0;
      last_inst = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Word fetch
      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
      do_req("fetch", 0, 0, 2'd0, 32'h100, 32'd0);
      check("fetch_inst", if_inst, 32'h0000_0513);

      // Contention: MEM wins, fetch accepted one cycle after mem_done
      poke(32'h20, 8'hF0);
      poke(32'h104, 8'h93); poke(32'h105, 8'h00); poke(32'h106, 8'h10); poke(32'h107, 8'h00);
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h20;
      if_req = 1'b1; if_addr = 32'h104;
      @(posedge clk);
      @(negedge clk);
      check("cont_first_addr", ram_a, 32'h20);
      e = 0; seen = 0;
      while (!seen && e < 20) begin
         @(posedge clk); e++;
         @(negedge clk);
         if (mem_done === 1'b1) seen = 1;
      end
      mem_req = 1'b0;
      check("cont_mem_done_seen", seen, 1);
      check("cont_mem_latency", e, 2);
      check("cont_mem_rdata", mem_rdata, 32'h0000_00F0);
      check("cont_busy_in_done", busy, 0);
      @(posedge clk);
      @(negedge clk);
      check("cont_if_not_in_done_cycle", busy, 0);
      @(posedge clk);
      @(negedge clk);
      check("cont_if_accepted", busy, 1);
      check("cont_if_addr", ram_a, 32'h104);
      e = 0; seen = 0;
      while (!seen && e < 20) begin
         @(posedge clk); e++;
         @(negedge clk);
         if (if_done === 1'b1) seen = 1;
      end
      if_req = 1'b0;
      check("cont_if_done_seen", seen, 1);
      check("cont_if_latency", e, 5);
      check("cont_if_inst", if_inst, 32'h0010_0093);
      last_inst = 32'h0010_0093;
      @(negedge clk);

      // Half write
      do_req("half_wr", 1, 1, 2'd1, 32'h1000, 32'hDEAD_BEEF);

      // Flush in the second cycle of a word fetch
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h300;
      @(posedge clk);
      @(negedge clk);
      check("flush_busy_before", busy, 1);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1; if_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_drop", busy, 0);
      quiet = 1;
      for (int i = 0; i < 4; i++) begin
         if (if_done !== 1'b0) quiet = 0;
         @(negedge clk);
      end
      check("flush_no_if_done", quiet, 1);
      check("flush_inst_unchanged", if_inst, last_inst);
      do_req("after_flush", 0, 0, 2'd0, 32'h200, 32'd0);

      // Reset during a word write after two bytes
      @(negedge clk);
      wlog.delete();
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h2000; mem_wdata = 32'h1122_3344;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("rst_mid_wr");
      rst = 1'b0; mem_req = 1'b0;
      quiet = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_done !== 1'b0 || ram_wr !== 1'b0) quiet = 0;
      end
      check("rst_mid_wr_quiet", quiet, 1);
      check("rst_mid_wr_count", wlog.size(), 2);
      if (wlog.size() >= 2) begin
         check("rst_mid_wr_b0", wlog[0], {32'h2000, 8'h44});
         check("rst_mid_wr_b1", wlog[1], {32'h2001, 8'h33});
      end
      ref_mem[32'h2000] = 8'h44;
      ref_mem[32'h2001] = 8'h33;
      last_inst = 32'd0;

      // Address wrap
      poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22);
      poke(32'h0000_0000, 8'h33); poke(32'h0000_0001, 8'h44);
      do_req("wrap", 0, 0, 2'd0, 32'hFFFF_FFFE, 32'd0);
      check("wrap_inst", if_inst, 32'h4433_2211);

      // Random traffic over a window straddling the top of the address space
      for (int i = 0; i < 40; i++) begin
         rl = 2'($urandom_range(0, 3));
         ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 31));
         case ($urandom_range(0, 2))
            0:       do_req("rnd_fetch", 0, 0, rl, ra, 32'd0);
            1:       do_req("rnd_rd",    1, 0, rl, ra, 32'd0);
            default: do_req("rnd_wr",    1, 1, rl, ra, $urandom);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
